// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-addressed data memory: sub-word loads with
// sign/zero extension, read-modify-write for byte/halfword stores.
module mem_access_unit #(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_adress,
  input  logic [31:0]       req_wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_adress,
  output logic [31:0]       mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state;
  logic              we_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_buf;
  logic              err_q;
  logic [31:0]       rdata_q;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return sgn ? 32'(b) : {24'b0, b};
      2'b01:   return sgn ? 32'(h) : {16'b0, h};
      default: return word;
    endcase
  endfunction

  // Replace only the addressed lane of the buffered word.
  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [1:0] off, input logic [1:0] size);
    logic [31:0] mask;
    logic [31:0] data;
    if (size == 2'b00) begin
      mask = 32'h0000_00FF << {off, 3'b000};
      data = {24'b0, wdata[7:0]} << {off, 3'b000};
    end else begin
      mask = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      data = off[1] ? {wdata[15:0], 16'b0} : {16'b0, wdata[15:0]};
    end
    return (word & ~mask) | (data & mask);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_buf <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_adress;
            wdata_q  <= req_wdata;
            if (misaligned(req_size, req_adress[1:0])) begin
              err_q <= 1'b1;
              state <= DONE;
            end else if (req_we && req_size == 2'b10) begin
              state <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          word_buf <= mem_read_data;
          if (!we_q) begin
            rdata_q <= load_extract(mem_read_data, addr_q[1:0], size_q, signed_q);
            state   <= DONE;
          end else begin
            state <= WRITE;
          end
        end
        WRITE: state <= DONE;
        DONE: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);
  assign err   = err_q;
  assign rdata = rdata_q;

  assign mem_write_data = (size_q == 2'b10) ? wdata_q
                                            : merge_lane(word_buf, wdata_q, addr_q[1:0], size_q);

  // mem_write follows rst_n so a reset landing on the WRITE cycle cancels the store.
  always_comb begin
    mem_adress = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state)
      READ: begin
        mem_adress = {addr_q[ADDR_W-1:2], 2'b00};
        mem_read   = 1'b1;
      end
      WRITE: begin
        mem_adress = {addr_q[ADDR_W-1:2], 2'b00};
        mem_write  = rst_n;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded bench for mem_access_unit with a behavioural word memory.
module tb_mem_access_unit;
  localparam int ADDR_W = 18;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [ADDR_W-1:0] req_adress = '0;
  logic [31:0]       req_wdata = '0;
  logic              ready, done, err;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] mem_adress;
  logic [31:0]       mem_write_data;
  logic              mem_write, mem_read;
  logic [31:0]       mem_read_data;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_adress(req_adress), .req_wdata(req_wdata),
    .ready(ready), .done(done), .err(err), .rdata(rdata),
    .mem_adress(mem_adress), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  logic        pre_en = 1'b0;
  logic [15:0] pre_idx = '0;
  logic [31:0] pre_val = '0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_write) mem[mem_adress[ADDR_W-1:2]] <= mem_write_data;
  end
  assign mem_read_data = mem[mem_adress[ADDR_W-1:2]];

  typedef struct {
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t e_q;
  int   checks = 0;
  int   errors = 0;
  int   rd_cycles = 0;
  int   wr_cycles = 0;

  // Monitor: pops an expectation on every done pulse.
  always @(negedge clk) begin
    if (mem_read) rd_cycles++;
    if (mem_write) wr_cycles++;
    if (mem_read && mem_write) begin
      checks++; errors++;
      $display("FAIL rw_exclusive: mem_read=%b mem_write=%b, required not both 1", mem_read, mem_write);
    end
    if (done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done=1 with no outstanding request");
      end else begin
        e_q = sb.pop_front();
        if (err !== e_q.err) begin
          errors++;
          $display("FAIL done_err: err=%b, required %b", err, e_q.err);
        end
        if (e_q.chk_rd) begin
          checks++;
          if (rdata !== e_q.rdata) begin
            errors++;
            $display("FAIL done_rdata: rdata=%h, required %h", rdata, e_q.rdata);
          end
        end
      end
    end
  end

  task automatic preload(input logic [15:0] idx, input logic [31:0] val);
    @(posedge clk); #2;
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge clk); #2;
    pre_en = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                       input logic e_err, input logic chk, input logic [31:0] e_rd,
                       input int e_lat, input string name);
    int  lat;
    int  w;
    bit  got;
    @(posedge clk); #2;
    w = 0;
    while (!ready && w < 20) begin
      @(posedge clk); #2;
      w++;
    end
    checks++;
    if (!ready) begin
      errors++;
      $display("FAIL %s_ready: ready=%b, required 1", name, ready);
    end
    req = 1'b1; req_we = we; req_size = size; req_signed = sgn; req_adress = a; req_wdata = wd;
    sb.push_back(exp_t'{e_err, chk, e_rd});
    rd_cycles = 0; wr_cycles = 0;
    @(posedge clk); #2;
    req = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_adress = ADDR_W'($urandom); req_wdata = $urandom;
    lat = 0; got = 0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (done) got = 1;
    end
    checks++;
    if (!got || lat != e_lat) begin
      errors++;
      $display("FAIL %s_latency: done after %0d cycles (seen=%0d), required %0d", name, lat, got, e_lat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 1'b1; req_we = 1'b1; req_size = 2'b10; req_adress = 18'h00010; req_wdata = 32'h1;
    repeat (3) @(posedge clk);
    #2; req = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b done=%b err=%b, required 1 0 0", ready, done, err);
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: rdata=%h, required 00000000", rdata);
    end
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_adress !== '0) begin
      errors++;
      $display("FAIL reset_mem_if: rd=%b wr=%b adr=%h, required 0 0 0", mem_read, mem_write, mem_adress);
    end
  endtask

  task automatic test_load_ext();
    preload(16'h0010, 32'h8899AABB);
    issue(1'b0, 2'b00, 1'b1, 18'h00043, 32'h0, 1'b0, 1'b1, 32'hFFFFFF88, 2, "lb_s43");
    issue(1'b0, 2'b00, 1'b0, 18'h00043, 32'h0, 1'b0, 1'b1, 32'h00000088, 2, "lb_u43");
    issue(1'b0, 2'b01, 1'b1, 18'h00040, 32'h0, 1'b0, 1'b1, 32'hFFFFAABB, 2, "lh_s40");
    issue(1'b0, 2'b01, 1'b0, 18'h00042, 32'h0, 1'b0, 1'b1, 32'h00008899, 2, "lh_u42");
    issue(1'b0, 2'b00, 1'b1, 18'h00041, 32'h0, 1'b0, 1'b1, 32'hFFFFFFAA, 2, "lb_s41");
    issue(1'b0, 2'b00, 1'b1, 18'h00040, 32'h0, 1'b0, 1'b1, 32'hFFFFFFBB, 2, "lb_s40");
    checks++;
    if (rd_cycles != 1 || wr_cycles != 0) begin
      errors++;
      $display("FAIL load_mem_cycles: reads=%0d writes=%0d, required 1 0", rd_cycles, wr_cycles);
    end
  endtask

  task automatic test_word_store();
    issue(1'b1, 2'b10, 1'b0, 18'h00010, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 2, "sw10");
    checks++;
    if (wr_cycles != 1 || rd_cycles != 0) begin
      errors++;
      $display("FAIL sw_mem_cycles: writes=%0d reads=%0d, required 1 0", wr_cycles, rd_cycles);
    end
    checks++;
    if (mem[4] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_mem: mem=%h, required DEADBEEF", mem[4]);
    end
    issue(1'b0, 2'b10, 1'b1, 18'h00010, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 2, "lw10");
  endtask

  task automatic test_subword_store();
    preload(16'h0008, 32'h11223344);
    issue(1'b1, 2'b00, 1'b0, 18'h00021, 32'hFFFFFFA5, 1'b0, 1'b0, 32'h0, 3, "sb21");
    checks++;
    if (mem[8] !== 32'h1122A544 || wr_cycles != 1 || rd_cycles != 1) begin
      errors++;
      $display("FAIL sb_mem: mem=%h wr=%0d rd=%0d, required 1122A544 1 1", mem[8], wr_cycles, rd_cycles);
    end
    issue(1'b1, 2'b01, 1'b0, 18'h00022, 32'h1234CAFE, 1'b0, 1'b0, 32'h0, 3, "sh22");
    checks++;
    if (mem[8] !== 32'hCAFEA544 || wr_cycles != 1 || rd_cycles != 1) begin
      errors++;
      $display("FAIL sh_mem: mem=%h wr=%0d rd=%0d, required CAFEA544 1 1", mem[8], wr_cycles, rd_cycles);
    end
  endtask

  task automatic test_errors();
    preload(16'h0000, 32'h0BADF00D);
    issue(1'b0, 2'b01, 1'b1, 18'h00041, 32'h0, 1'b1, 1'b0, 32'h0, 1, "err_lh41");
    issue(1'b1, 2'b10, 1'b0, 18'h00042, 32'h55555555, 1'b1, 1'b0, 32'h0, 1, "err_sw42");
    checks++;
    if (mem[16] !== 32'h8899AABB || rd_cycles != 0 || wr_cycles != 0) begin
      errors++;
      $display("FAIL err_sw42_mem: mem=%h rd=%0d wr=%0d, required 8899AABB 0 0", mem[16], rd_cycles, wr_cycles);
    end
    issue(1'b1, 2'b11, 1'b0, 18'h00000, 32'h77777777, 1'b1, 1'b0, 32'h0, 1, "err_sz11");
    checks++;
    if (mem[0] !== 32'h0BADF00D || rd_cycles != 0 || wr_cycles != 0) begin
      errors++;
      $display("FAIL err_sz11_mem: mem=%h rd=%0d wr=%0d, required 0BADF00D 0 0", mem[0], rd_cycles, wr_cycles);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b, required 0", err);
    end
  endtask

  task automatic test_reset_mid_write();
    preload(16'h0008, 32'h11223344);
    @(posedge clk); #2;
    req = 1'b1; req_we = 1'b1; req_size = 2'b00; req_adress = 18'h00020; req_wdata = 32'h77;
    @(posedge clk); #2;
    req = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (mem_write !== 1'b1) begin
      errors++;
      $display("FAIL rstw_in_write: mem_write=%b, required 1", mem_write);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0) begin
      errors++;
      $display("FAIL rstw_suppress: mem_write=%b, required 0", mem_write);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (mem[8] !== 32'h11223344 || ready !== 1'b1 || done !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL rstw_after: mem=%h ready=%b done=%b rdata=%h, required 11223344 1 0 00000000",
               mem[8], ready, done, rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] addrs [3];
    logic [31:0]       vals [3];
    int i;
    int cyc;
    int w;
    addrs[0] = 18'h00000; addrs[1] = 18'h00004; addrs[2] = 18'h00008;
    vals[0] = 32'hA1B2C3D4; vals[1] = 32'h12345678; vals[2] = 32'hCAFEBABE;
    for (int k = 0; k < 3; k++) preload(16'(k), vals[k]);
    @(posedge clk); #2;
    i = 0; cyc = 0;
    req = 1'b1;
    while (i < 3 && cyc < 40) begin
      if (ready) begin
        req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_adress = addrs[i];
        sb.push_back(exp_t'{1'b0, 1'b1, vals[i]});
        i++;
      end else begin
        req_we = 1'($urandom); req_size = 2'($urandom); req_adress = ADDR_W'($urandom);
        req_wdata = $urandom;
      end
      @(posedge clk); #2;
      cyc++;
    end
    req = 1'b0;
    w = 0;
    while (sb.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (i != 3 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_complete: accepted=%0d pending=%0d, required 3 0", i, sb.size());
    end
    repeat (3) @(negedge clk);
    checks++;
    if (mem[0] !== vals[0] || mem[1] !== vals[1] || mem[2] !== vals[2]) begin
      errors++;
      $display("FAIL b2b_mem: %h %h %h, required %h %h %h", mem[0], mem[1], mem[2], vals[0], vals[1], vals[2]);
    end
  endtask

  task automatic test_top_addr();
    preload(16'hFFFF, 32'h5A5AA5A5);
    issue(1'b0, 2'b10, 1'b0, 18'h3FFFC, 32'h0, 1'b0, 1'b1, 32'h5A5AA5A5, 2, "lw_top");
    issue(1'b0, 2'b00, 1'b0, 18'h3FFFF, 32'h0, 1'b0, 1'b1, 32'h0000005A, 2, "lbu_top");
    issue(1'b1, 2'b01, 1'b0, 18'h3FFFC, 32'h0000BEEF, 1'b0, 1'b0, 32'h0, 3, "sh_top");
    checks++;
    if (mem[16'hFFFF] !== 32'h5A5ABEEF) begin
      errors++;
      $display("FAIL sh_top_mem: mem=%h, required 5A5ABEEF", mem[16'hFFFF]);
    end
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_word_store();
    test_subword_store();
    test_errors();
    test_reset_mid_write();
    test_back_to_back();
    test_top_addr();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations never completed", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface: the core's load/store unit driving the word-addressed data memory.
- The memory has a combinational read and a write on the rising clock edge. It accepts only whole, word-aligned words.
- This block handles byte, halfword and word accesses. It performs sign/zero extension on loads and read-modify-write for sub-word stores.
- Misaligned and illegal-size requests are flagged without touching memory.

Parameters:
- ADDR_W, 18, byte-address width; word address is bits [ADDR_W-1:2].

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req  in  1  access request; sampled only when ready=1.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  load sign-extend when 1, zero-extend when 0.
- req_adress  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- ready  out  1  block idle and able to accept req.
- done  out  1  one-cycle completion pulse.
- err  out  1  misaligned/illegal flag, valid with done.
- rdata  out  32  load result, valid with done, held until next load completes.
- mem_adress  out  ADDR_W  to memory; low two bits always 00.
- mem_write_data  out  32  to memory.
- mem_write  out  1  to memory.
- mem_read  out  1  to memory.
- mem_read_data  in  32  from memory, combinational.

Behaviour:
- Reset
  - Applied at a rising edge with rst_n=0.
  - State becomes IDLE; done, err and rdata are 0; latched request fields are 0.
  - mem_write, mem_read and mem_adress read 0 while in IDLE.
- States: IDLE, READ, WRITE, DONE.
- IDLE
  - ready=1.
  - If req=1, latch req_we, req_size, req_signed, req_adress and req_wdata at the edge. Next state depends on the request:
    - Misaligned or illegal → DONE with err=1. Misaligned means halfword with adress[0]=1, word with adress[1:0]≠00, or size 11.
    - Load → READ.
    - Word store → WRITE.
    - Byte/halfword store → READ.
- READ
  - mem_adress = {latched adress[ADDR_W-1:2],2'b00}, mem_read=1, mem_write=0.
  - At the edge, capture mem_read_data into word_buf.
  - For a load, also register the extracted rdata and go to DONE.
  - For a sub-word store, go to WRITE.
- Lanes are little-endian:
  - Byte offset k selects bits [8k+7:8k].
  - Halfword offset 0 selects [15:0]; offset 2 selects [31:16].
  - Signed loads replicate the top bit of the selected lane; unsigned loads zero-fill.
- WRITE
  - mem_adress is the aligned address.
  - mem_write = rst_n, i.e. forced 0 when reset is asserted in this cycle, so a reset mid-operation suppresses the write.
  - mem_write_data:
    - Word store: latched wdata.
    - Sub-word store: word_buf with only the addressed lane replaced by wdata[7:0] or wdata[15:0].
  - Next state is DONE.
- DONE
  - done=1 and ready=0 for exactly one cycle; err holds its value.
  - Next state is IDLE. err clears when leaving DONE.
- Latency, counted from the accepting edge E0 (done high in the cycle after the listed edge):
  - Error: done after E0, no memory access.
  - Word store: memory written at E1, done after E1.
  - Load: done after E1.
  - Sub-word store: memory written at E2, done after E2.
- Other rules:
  - req while ready=0 is ignored and not queued.
  - req_* may change freely after acceptance; only latched copies are used.
  - mem_read and mem_write are never both 1.
  - A reset at any state returns to IDLE with no done pulse.
  - Address wrap is not applicable; the top word address 0xFFFF is accessed normally.

Test Plan:
- Memory word 0x40 = 0x8899AABB:
  - load byte signed @0x43 → rdata 0xFFFFFF88, done 2 cycles after accept, err 0.
  - Same access unsigned → 0x00000088.
  - Halfword signed @0x40 → 0xFFFFAABB.
- Word store 0xDEADBEEF @0x10 → mem_write high exactly one cycle; a subsequent word load @0x10 returns 0xDEADBEEF.
- Memory word 0x20 = 0x11223344:
  - byte store 0xA5 @0x21 → memory becomes 0x1122A544.
  - halfword store 0xCAFE @0x22 → memory becomes 0xCAFEA544.
  - Each write occurs 2 edges after accept.
- Halfword load @0x41, word store @0x42, size 11 @0x00 → done with err=1 one cycle after accept; mem_read and mem_write stay 0; memory unchanged.
- Sub-word store, rst_n driven 0 during the WRITE cycle → mem_write 0 at that edge, memory unchanged, state IDLE, no done.
- Back-to-back req held high → each accepted only when ready=1; consecutive loads from 0x00, 0x04, 0x08 return the three words in order, one done per access.
